hazard_detection_unit: RTL and testbench

- ID-stage companion to the EX-stage forwarding logic in the 5-stage MIPS pipeline.
- Forwarding resolves a dependency by supplying a value. This block resolves the cases forwarding cannot: load-use hazards, which need a stall, and taken branches/jumps, which need an IF/ID flush.
- Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble insert.
- Keeps saturating stall and flush counters for performance measurement.

---
 rtl/hazard_detection_unit_if.sv | 27 ++
 rtl/hazard_detection_unit.sv | 61 ++++++
 tb/tb_hazard_detection_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: pipeline-side hazard inputs and stall/flush controls for the ID-stage hazard unit
interface hazard_detection_unit_if #(parameter int COUNT_WIDTH = 16);
  logic id_ex_mem_read;
  logic [4:0] id_ex_write_register;
  logic [4:0] if_id_read_register_1;
  logic [4:0] if_id_read_register_2;
  logic if_id_uses_rt;
  logic branch_taken;
  logic jump;
  logic pc_write;
  logic if_id_write;
  logic id_ex_bubble;
  logic if_id_flush;
  logic stall_active;
  logic [COUNT_WIDTH-1:0] stall_count;
  logic [COUNT_WIDTH-1:0] flush_count;
  modport master (
    output id_ex_mem_read, id_ex_write_register, if_id_read_register_1, if_id_read_register_2,
           if_id_uses_rt, branch_taken, jump,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active, stall_count, flush_count
  );
  modport slave (
    input  id_ex_mem_read, id_ex_write_register, if_id_read_register_1, if_id_read_register_2,
           if_id_uses_rt, branch_taken, jump,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use stall and branch/jump flush control with saturating perf counters
module hazard_detection_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  hazard_detection_unit_if.slave bus
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state, state_n;
  logic [3:0] rem, rem_n;
  logic hazard, stall, flush;
  logic [COUNT_WIDTH-1:0] stall_count, flush_count;
  assign hazard = bus.id_ex_mem_read && bus.id_ex_write_register != 5'd0 &&
                  (bus.id_ex_write_register == bus.if_id_read_register_1 ||
                   (bus.if_id_uses_rt && bus.id_ex_write_register == bus.if_id_read_register_2));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem <= 4'd0;
    end else begin
      state <= state_n;
      rem <= rem_n;
    end
  end
  always_comb begin
    state_n = state;
    rem_n = rem;
    if (state == IDLE) begin
      if (hazard && LOAD_STALL_CYCLES > 1) begin
        state_n = STALL;
        rem_n = 4'(LOAD_STALL_CYCLES - 1);
      end
    end else begin
      rem_n = rem - 4'd1;
      state_n = (rem == 4'd1) ? IDLE : STALL;
    end
  end
  // reset gates the Mealy hazard term so outputs are clean while reset is held
  always_comb begin
    stall = !reset && (state == STALL || hazard);
    flush = !reset && (bus.branch_taken || bus.jump) && !stall;
    bus.pc_write = !stall;
    bus.if_id_write = !stall;
    bus.id_ex_bubble = stall;
    bus.if_id_flush = flush;
    bus.stall_active = state == STALL;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed checks of stall, flush, reset and counter saturation
module tb_hazard_detection_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  hazard_detection_unit_if #(.COUNT_WIDTH(16)) b1 ();
  hazard_detection_unit_if #(.COUNT_WIDTH(16)) b3 ();
  hazard_detection_unit_if #(.COUNT_WIDTH(16)) b4 ();
  hazard_detection_unit_if #(.COUNT_WIDTH(2)) bw ();
  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .COUNT_WIDTH(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
  hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .COUNT_WIDTH(16)) u3 (.clk(clk), .reset(reset), .bus(b3));
  hazard_detection_unit #(.LOAD_STALL_CYCLES(4), .COUNT_WIDTH(16)) u4 (.clk(clk), .reset(reset), .bus(b4));
  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .COUNT_WIDTH(2)) uw (.clk(clk), .reset(reset), .bus(bw));
  logic [4:0] o1, o3, o4, ow;
  assign o1 = {b1.pc_write, b1.if_id_write, b1.id_ex_bubble, b1.if_id_flush, b1.stall_active};
  assign o3 = {b3.pc_write, b3.if_id_write, b3.id_ex_bubble, b3.if_id_flush, b3.stall_active};
  assign o4 = {b4.pc_write, b4.if_id_write, b4.id_ex_bubble, b4.if_id_flush, b4.stall_active};
  assign ow = {bw.pc_write, bw.if_id_write, bw.id_ex_bubble, bw.if_id_flush, bw.stall_active};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    {b1.id_ex_mem_read, b1.id_ex_write_register, b1.if_id_read_register_1, b1.if_id_read_register_2, b1.if_id_uses_rt, b1.branch_taken, b1.jump} = '0;
    {b3.id_ex_mem_read, b3.id_ex_write_register, b3.if_id_read_register_1, b3.if_id_read_register_2, b3.if_id_uses_rt, b3.branch_taken, b3.jump} = '0;
    {b4.id_ex_mem_read, b4.id_ex_write_register, b4.if_id_read_register_1, b4.if_id_read_register_2, b4.if_id_uses_rt, b4.branch_taken, b4.jump} = '0;
    {bw.id_ex_mem_read, bw.id_ex_write_register, bw.if_id_read_register_1, bw.if_id_read_register_2, bw.if_id_uses_rt, bw.branch_taken, bw.jump} = '0;
  endtask

  task automatic test_reset();
    b1.id_ex_mem_read = 1; b1.id_ex_write_register = 8; b1.if_id_read_register_1 = 8; b1.branch_taken = 1;
    #2;
    total++; if (o1 !== 5'b11000) begin bad++; $display("FAIL reset_outs got=%b exp=11000", o1); end
    total++; if (b1.stall_count !== 16'd0 || b1.flush_count !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", b1.stall_count, b1.flush_count); end
    clear_all();
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic test_load_use();
    b1.id_ex_mem_read = 1; b1.id_ex_write_register = 8; b1.if_id_read_register_1 = 8;
    #2;
    total++; if (o1 !== 5'b00100) begin bad++; $display("FAIL lu_stall got=%b exp=00100", o1); end
    total++; if (b1.stall_count !== 16'd0) begin bad++; $display("FAIL lu_cnt0 got=%0d exp=0", b1.stall_count); end
    cyc();
    total++; if (b1.stall_count !== 16'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=1", b1.stall_count); end
    b1.id_ex_mem_read = 0;
    #2;
    total++; if (o1 !== 5'b11000) begin bad++; $display("FAIL lu_release got=%b exp=11000", o1); end
    cyc();
  endtask

  task automatic test_reg_select();
    b1.id_ex_mem_read = 1; b1.id_ex_write_register = 0; b1.if_id_read_register_1 = 0;
    #2;
    total++; if (o1 !== 5'b11000) begin bad++; $display("FAIL rs_r0 got=%b exp=11000", o1); end
    b1.id_ex_write_register = 9; b1.if_id_read_register_1 = 1; b1.if_id_read_register_2 = 9; b1.if_id_uses_rt = 0;
    #1;
    total++; if (o1 !== 5'b11000) begin bad++; $display("FAIL rs_rt_unused got=%b exp=11000", o1); end
    b1.if_id_uses_rt = 1;
    #1;
    total++; if (o1 !== 5'b00100) begin bad++; $display("FAIL rs_rt_used got=%b exp=00100", o1); end
    cyc();
    clear_all();
    total++; if (b1.stall_count !== 16'd2) begin bad++; $display("FAIL rs_cnt got=%0d exp=2", b1.stall_count); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_o [4] = '{5'b00100, 5'b00101, 5'b00101, 5'b11000};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0) begin b3.id_ex_mem_read = 1; b3.id_ex_write_register = 5; b3.if_id_read_register_2 = 5; b3.if_id_uses_rt = 1; end
        #2;
        total++; if (o3 !== exp_o[k]) begin bad++; $display("FAIL b2b r%0d k%0d got=%b exp=%b", r, k, o3, exp_o[k]); end
        if (k < 3) begin cyc(); clear_all(); end
      end
      total++; if (b3.stall_count !== 16'(3 * (r + 1))) begin bad++; $display("FAIL b2b_cnt r%0d got=%0d exp=%0d", r, b3.stall_count, 3 * (r + 1)); end
    end
    cyc();
  endtask

  task automatic test_flush();
    b1.id_ex_mem_read = 1; b1.id_ex_write_register = 8; b1.if_id_read_register_1 = 8; b1.branch_taken = 1;
    #2;
    total++; if (o1 !== 5'b00100) begin bad++; $display("FAIL fl_prio got=%b exp=00100", o1); end
    cyc();
    b1.id_ex_mem_read = 0;
    #2;
    total++; if (o1 !== 5'b11010) begin bad++; $display("FAIL fl_branch got=%b exp=11010", o1); end
    total++; if (b1.flush_count !== 16'd0) begin bad++; $display("FAIL fl_cnt0 got=%0d exp=0", b1.flush_count); end
    cyc();
    total++; if (b1.flush_count !== 16'd1) begin bad++; $display("FAIL fl_cnt1 got=%0d exp=1", b1.flush_count); end
    b1.branch_taken = 0; b1.jump = 1;
    #2;
    total++; if (o1 !== 5'b11010) begin bad++; $display("FAIL fl_jump got=%b exp=11010", o1); end
    cyc();
    clear_all();
    total++; if (b1.flush_count !== 16'd2) begin bad++; $display("FAIL fl_cnt2 got=%0d exp=2", b1.flush_count); end
    cyc();
  endtask

  task automatic test_async_reset();
    b4.id_ex_mem_read = 1; b4.id_ex_write_register = 8; b4.if_id_read_register_1 = 8;
    cyc();
    cyc();
    #2;
    total++; if (o4 !== 5'b00101) begin bad++; $display("FAIL ar_stall2 got=%b exp=00101", o4); end
    total++; if (b4.stall_count !== 16'd2) begin bad++; $display("FAIL ar_cnt got=%0d exp=2", b4.stall_count); end
    reset = 1;
    #1;
    total++; if (o4 !== 5'b11000) begin bad++; $display("FAIL ar_outs got=%b exp=11000", o4); end
    total++; if (b4.stall_count !== 16'd0 || b4.flush_count !== 16'd0) begin bad++; $display("FAIL ar_counts got=%0d/%0d exp=0/0", b4.stall_count, b4.flush_count); end
    cyc();
    clear_all();
    reset = 0;
    cyc();
    #2;
    total++; if (o4 !== 5'b11000) begin bad++; $display("FAIL ar_after got=%b exp=11000", o4); end
    total++; if (b4.stall_count !== 16'd0) begin bad++; $display("FAIL ar_after_cnt got=%0d exp=0", b4.stall_count); end
    cyc();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      bw.id_ex_mem_read = 1; bw.id_ex_write_register = 3; bw.if_id_read_register_1 = 3;
      cyc();
      clear_all();
      total++; if (bw.stall_count !== 2'((i < 3) ? i + 1 : 3)) begin bad++; $display("FAIL sat i%0d got=%0d exp=%0d", i, bw.stall_count, (i < 3) ? i + 1 : 3); end
      cyc();
    end
  endtask

  initial begin
    clear_all();
    #1;
    test_reset();
    test_load_use();
    test_reg_select();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
